traffic_light_ctrl: RTL

- Parametrised successor of the fixed 16-cycle traffic light.
- Runs the sequence RED -> ORANGE -> GREEN -> RED.
- Phase lengths are set by parameters and counted in tick strobes, not raw clocks.
- Adds pedestrian-request green shortening, registered one-hot lamp outputs and phase/remaining-time status for a supervisor or display block.

---
 rtl/tl_pkg.sv | 14 +
 rtl/traffic_light_ctrl_if.sv | 21 ++
 rtl/tl_phase_timer.sv | 17 +
 rtl/traffic_light_ctrl.sv | 67 ++++++
 4 files changed

// File: rtl/tl_pkg.sv
// tl_pkg: phase codes, default phase durations and phase helpers for traffic_light_ctrl
package tl_pkg;
  typedef enum logic [1:0] {RED = 2'd0, ORANGE = 2'd1, GREEN = 2'd2, FLASH = 2'd3} phase_e;
  localparam int RED_DUR = 9;
  localparam int ORANGE_DUR = 3;
  localparam int GREEN_DUR = 4;
  localparam int FLASH_DUR = 1;
  function automatic int dur_of(phase_e p);
    return p == RED ? RED_DUR : p == ORANGE ? ORANGE_DUR : p == GREEN ? GREEN_DUR : FLASH_DUR;
  endfunction
  function automatic phase_e next_phase(phase_e p);
    return p == RED ? ORANGE : p == ORANGE ? GREEN : RED;
  endfunction
endpackage

// File: rtl/traffic_light_ctrl_if.sv
// traffic_light_ctrl_if: controller bus; master drives tick/ped_req(/flash_req with TL_FLASH_EN), slave returns lamps, phase, remain, ped_wait
interface traffic_light_ctrl_if import tl_pkg::*; #(parameter int CNT_W = 8);
  logic tick;
  logic ped_req;
`ifdef TL_FLASH_EN
  logic flash_req;
`endif
  logic red;
  logic orange;
  logic green;
  phase_e phase;
  logic [CNT_W-1:0] remain;
  logic ped_wait;
`ifdef TL_FLASH_EN
  modport master (output tick, ped_req, flash_req, input red, orange, green, phase, remain, ped_wait);
  modport slave (input tick, ped_req, flash_req, output red, orange, green, phase, remain, ped_wait);
`else
  modport master (output tick, ped_req, input red, orange, green, phase, remain, ped_wait);
  modport slave (input tick, ped_req, output red, orange, green, phase, remain, ped_wait);
`endif
endinterface

// File: rtl/tl_phase_timer.sv
// tl_phase_timer: tick-enabled phase counter; ports clk, reset, en, clr, limit in; cnt, term (cnt==limit-1) out
module tl_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (en) cnt <= cnt + CNT_W'(1);
  assign term = cnt == limit - CNT_W'(1);
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: tick-timed RED->ORANGE->GREEN light with pedestrian green shortening; ports clk, reset, bus (slave); TL_FLASH_EN adds flash_req and the FLASH phase
module traffic_light_ctrl import tl_pkg::*; #(
  parameter int RED_TICKS = dur_of(RED),
  parameter int ORANGE_TICKS = dur_of(ORANGE),
  parameter int GREEN_TICKS = dur_of(GREEN),
  parameter int MIN_GREEN = 2,
  parameter int CNT_W = 8,
  parameter int FLASH_TICKS = dur_of(FLASH)
) (
  input logic clk,
  input logic reset,
  traffic_light_ctrl_if.slave bus
);
  phase_e phase_q, phase_d;
  logic [CNT_W-1:0] cnt, limit;
  logic term, clr, adv, short_g;
  logic red_q, orange_q, green_q, ped_q;
  logic orange_d, ped_d;
  tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .reset(reset),
    .en(bus.tick),
    .clr(clr),
    .limit(limit),
    .cnt(cnt),
    .term(term)
  );
  always_comb begin
    limit = phase_q == ORANGE ? CNT_W'(ORANGE_TICKS) :
            phase_q == GREEN  ? CNT_W'(GREEN_TICKS)  :
            phase_q == FLASH  ? CNT_W'(FLASH_TICKS)  : CNT_W'(RED_TICKS);
    short_g = phase_q == GREEN && ped_q && cnt >= CNT_W'(MIN_GREEN - 1);
    adv = bus.tick && (term || short_g);
    phase_d = adv ? next_phase(phase_q) : phase_q;
    clr = adv;
    ped_d = (phase_q == RED || (adv && phase_d == RED)) ? 1'b0 : ped_q || bus.ped_req;
    orange_d = phase_d == ORANGE;
`ifdef TL_FLASH_EN
    if (bus.flash_req || phase_q == FLASH) begin
      phase_d = bus.flash_req ? FLASH : RED;
      clr = phase_q != FLASH || !bus.flash_req || (bus.tick && term);
      ped_d = 1'b0;
      orange_d = bus.flash_req && (phase_q != FLASH || (orange_q ^ (bus.tick && term)));
    end
`endif
  end
  always_ff @(posedge clk)
    if (reset) begin
      phase_q <= RED;
      red_q <= 1'b1;
      orange_q <= 1'b0;
      green_q <= 1'b0;
      ped_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      red_q <= phase_d == RED;
      orange_q <= orange_d;
      green_q <= phase_d == GREEN;
      ped_q <= ped_d;
    end
  assign bus.red = red_q;
  assign bus.orange = orange_q;
  assign bus.green = green_q;
  assign bus.phase = phase_q;
  assign bus.remain = limit - CNT_W'(1) - cnt;
  assign bus.ped_wait = ped_q;
endmodule
